sc_fifo: RTL and testbench
==========================

Name: sc_fifo

Overview:
- Single-clock synchronous byte FIFO that decouples a pixel-reformatting producer from a downstream encoder consumer.
- Provides registered read data, full/empty and almost flags, and a live occupancy count.
- The producer throttles on cnt, e.g. it writes only while cnt < DEPTH-10.
- Storage is an inferred dual-port RAM with one write port and one read port.

Parameters:
- DW, 8: data width in bits.
- DEPTH, 512: number of entries; must be a power of two.
- AW, 9: pointer width, log2(DEPTH).
- CW, 10: count width, AW+1, so cnt can represent DEPTH.
- AF_MARGIN, 8: almost_full asserts when cnt >= DEPTH-AF_MARGIN.
- AE_MARGIN, 8: almost_empty asserts when cnt <= AE_MARGIN.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  DW  write data.
- write  in  1  write request, sampled on the rising clk edge.
- read  in  1  read request, sampled on the rising clk edge.
- clear  in  1  synchronous flush.
- data_out  out  DW  registered read data.
- full  out  1  cnt == DEPTH.
- almost_full  out  1  cnt >= DEPTH-AF_MARGIN.
- empty  out  1  cnt == 0.
- almost_empty  out  1  cnt <= AE_MARGIN.
- cnt  out  CW  current occupancy, 0..DEPTH.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, cnt = 0, data_out = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
- Write acceptance: wr_ok = write && !full.
  - On wr_ok: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH.
  - Write while full is dropped: no state change, no error flag.
- Read acceptance: rd_ok = read && !empty.
  - On rd_ok: data_out <= mem[rd_ptr] at that edge, so data is valid the cycle after read (1-cycle latency); rd_ptr increments modulo DEPTH.
  - Read while empty is ignored; data_out holds its last value.
  - data_out holds whenever there is no accepted read.
- Count update:
  - cnt += 1 on wr_ok && !rd_ok.
  - cnt -= 1 on rd_ok && !wr_ok.
  - cnt is unchanged when both or neither are accepted.
- Flags are combinational decodes of the registered cnt, so they update in the same cycle as cnt.
- Simultaneous read and write:
  - Empty: only the write is accepted; the new data is not readable until the next cycle (no fall-through).
  - Full: only the read is accepted (write blocked by full); cnt becomes DEPTH-1.
  - Otherwise: both are accepted and cnt is unchanged.
- Pointer wrap: pointers are AW bits and wrap naturally from DEPTH-1 to 0. Full/empty are derived from cnt, not from pointer comparison.
- clear (synchronous, priority over read/write):
  - wr_ptr, rd_ptr and cnt go to 0 on the edge; read and write in that cycle are discarded.
  - data_out holds its value; memory contents are not cleared.
- Reset mid-operation forces the reset values immediately, asynchronously; memory contents are don't-care.
- Memory has no reset and is read through the read port only; no read-during-write hazard exists because a read never targets the slot being written unless cnt == 0, and that case is blocked.

Decomposition:
- No shared package is needed. Parameters are local to the module; a caller needing a DEPTH-relative threshold computes it from DEPTH.
- One natural sub-module: sc_fifo_ram, a simple dual-port DW x DEPTH RAM with a synchronous write and a registered synchronous read (read enable = rd_ok).
- Pointers, count and flags stay in sc_fifo.

Test Plan:
- Reset: assert reset mid-stream after 5 writes -> cnt = 0, empty = 1, almost_empty = 1, data_out = 0 immediately and asynchronously.
- Order/latency: write 0x11, 0x22, 0x33 on consecutive cycles, then read 3 cycles -> data_out = 0x11, 0x22, 0x33 on the cycles after each read; cnt steps 3, 2, 1, 0; empty = 1 at the end.
- Fill: write 512 bytes (i & 0xFF) -> almost_full asserts at cnt = 504, full at cnt = 512; a 513th write of 0xAA is dropped; draining 512 reads yields 0x00..0xFF twice with no 0xAA.
- Boundaries: read on empty -> cnt stays 0 and data_out unchanged. Read+write on empty -> cnt = 1. Read+write at cnt = 512 -> cnt = 511. Read+write at cnt = 100 -> cnt = 100 with correct order.
- Wrap: run 1200 interleaved writes/reads keeping cnt between 200 and 300 -> output sequence matches input exactly across pointer wrap.
- clear: with cnt = 37, assert clear together with write = 1 and read = 1 -> cnt = 0, empty = 1, data_out unchanged; a subsequent write 0x5C then read returns 0x5C.

Source files
------------

// File: rtl/sc_fifo_ram.sv
// Simple dual-port DW x DEPTH RAM used as the sc_fifo storage array.
// One synchronous write port and one registered synchronous read port.
// The array itself has no reset; only the read data register is reset so
// the FIFO output starts at zero.
module sc_fifo_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wrEn_i,
  input  logic [AW-1:0] wrAddr_i,
  input  logic [DW-1:0] wrData_i,
  input  logic          rdEn_i,
  input  logic [AW-1:0] rdAddr_i,
  output logic [DW-1:0] rdData_o
);

  logic [DW-1:0] mem [DEPTH];

  // Write port: store incoming data at the write address when enabled.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
  end

  // Read port: register the addressed word on an accepted read, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdData_o <= '0;
    end else if (rdEn_i) begin
      rdData_o <= mem[rdAddr_i];
    end
  end

endmodule

// File: rtl/sc_fifo.sv
// Single-clock byte FIFO between the pixel reformatter and the encoder.
// Occupancy is tracked in an explicit counter; full/empty and the almost
// flags are decoded from that counter rather than from pointer comparison.
module sc_fifo #(
  parameter int DW        = 8,
  parameter int DEPTH     = 512,
  parameter int AW        = 9,
  parameter int CW        = 10,
  parameter int AF_MARGIN = 8,
  parameter int AE_MARGIN = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data_in,
  input  logic          write,
  input  logic          read,
  input  logic          clear,
  output logic [DW-1:0] data_out,
  output logic          full,
  output logic          almost_full,
  output logic          empty,
  output logic          almost_empty,
  output logic [CW-1:0] cnt
);

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrOk;
  logic          rdOk;

  // A flush discards any read or write presented in the same cycle.
  assign wrOk = write && !full  && !clear;
  assign rdOk = read  && !empty && !clear;

  // Next-state for pointers and occupancy; clear wins over everything else.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    if (clear) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      cnt_d   = '0;
    end else begin
      if (wrOk) begin
        wrPtr_d = wrPtr_q + AW'(1);
      end
      if (rdOk) begin
        rdPtr_d = rdPtr_q + AW'(1);
      end
      if (wrOk && !rdOk) begin
        cnt_d = cnt_q + CW'(1);
      end else if (rdOk && !wrOk) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status flags follow the registered count in the same cycle.
  assign cnt          = cnt_q;
  assign full         = (cnt_q == CW'(DEPTH));
  assign almost_full  = (cnt_q >= CW'(DEPTH - AF_MARGIN));
  assign empty        = (cnt_q == '0);
  assign almost_empty = (cnt_q <= CW'(AE_MARGIN));

  sc_fifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk      (clk),
    .reset    (reset),
    .wrEn_i   (wrOk),
    .wrAddr_i (wrPtr_q),
    .wrData_i (data_in),
    .rdEn_i   (rdOk),
    .rdAddr_i (rdPtr_q),
    .rdData_o (data_out)
  );

endmodule

// File: tb/tb_sc_fifo.sv
// Directed testbench for sc_fifo. A queue-based reference model of the FIFO
// predicts occupancy, flags and read data each cycle; hand-computed constants
// are checked at the interesting points (thresholds, wrap, clear).
module tb_sc_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 512;
  localparam int CW    = 10;

  logic          clk;
  logic          reset;
  logic [DW-1:0] dataIn;
  logic          write;
  logic          read;
  logic          clear;
  logic [DW-1:0] dataOut;
  logic          full;
  logic          almostFull;
  logic          empty;
  logic          almostEmpty;
  logic [CW-1:0] cnt;

  int       checkCount = 0;
  int       errorCount = 0;
  bit [7:0] modelQ[$];
  bit [7:0] expData = 8'h00;

  sc_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (dataIn),
    .write        (write),
    .read         (read),
    .clear        (clear),
    .data_out     (dataOut),
    .full         (full),
    .almost_full  (almostFull),
    .empty        (empty),
    .almost_empty (almostEmpty),
    .cnt          (cnt)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Compare every DUT output against the reference model state.
  task automatic compareState();
    int sz;
    sz = modelQ.size();
    checkOutput("cnt", 32'(cnt), 32'(sz));
    checkOutput("data_out", 32'(dataOut), 32'(expData));
    checkOutput("empty", 32'(empty), 32'(sz == 0));
    checkOutput("full", 32'(full), 32'(sz == DEPTH));
    checkOutput("almost_empty", 32'(almostEmpty), 32'(sz <= 8));
    checkOutput("almost_full", 32'(almostFull), 32'(sz >= DEPTH - 8));
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic applyStimulus(input logic w, input logic r, input logic c,
                               input logic [7:0] d);
    bit rdOk;
    bit wrOk;
    @(negedge clk);
    write  = w;
    read   = r;
    clear  = c;
    dataIn = d;
    if (c) begin
      modelQ.delete();
    end else begin
      rdOk = r && (modelQ.size() > 0);
      wrOk = w && (modelQ.size() < DEPTH);
      if (rdOk) expData = modelQ.pop_front();
      if (wrOk) modelQ.push_back(d);
    end
    @(posedge clk);
    #1;
    compareState();
  endtask

  initial begin
    reset  = 1'b1;
    write  = 1'b0;
    read   = 1'b0;
    clear  = 1'b0;
    dataIn = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compareState();
    reset = 1'b0;

    // Order and latency: three writes then three reads.
    applyStimulus(1, 0, 0, 8'h11);
    applyStimulus(1, 0, 0, 8'h22);
    applyStimulus(1, 0, 0, 8'h33);
    checkOutput("order_cnt3", 32'(cnt), 32'd3);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("order_rd1", 32'(dataOut), 32'h11);
    checkOutput("order_cnt2", 32'(cnt), 32'd2);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("order_rd2", 32'(dataOut), 32'h22);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("order_rd3", 32'(dataOut), 32'h33);
    checkOutput("order_cnt0", 32'(cnt), 32'd0);
    checkOutput("order_empty", 32'(empty), 32'd1);

    // Read on empty: count stays zero, data_out holds 0x33.
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("rd_empty_cnt", 32'(cnt), 32'd0);
    checkOutput("rd_empty_hold", 32'(dataOut), 32'h33);

    // Read+write on empty: only the write lands, no fall-through.
    applyStimulus(1, 1, 0, 8'h77);
    checkOutput("rw_empty_cnt", 32'(cnt), 32'd1);
    checkOutput("rw_empty_hold", 32'(dataOut), 32'h33);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("rw_empty_rd", 32'(dataOut), 32'h77);

    // Fill to DEPTH with i & 0xFF, checking threshold crossings.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 0, 0, 8'(i));
      if (i == 502) checkOutput("af_at_503", 32'(almostFull), 32'd0);
      if (i == 503) checkOutput("af_at_504", 32'(almostFull), 32'd1);
      if (i == 510) checkOutput("full_at_511", 32'(full), 32'd0);
      if (i == 511) checkOutput("full_at_512", 32'(full), 32'd1);
    end
    applyStimulus(1, 0, 0, 8'hAA);
    checkOutput("drop_cnt", 32'(cnt), 32'd512);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 1, 0, 8'h00);
      checkOutput("drain_data", 32'(dataOut), 32'(i & 8'hFF));
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);

    // Read+write at full: only the read is accepted.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 8'(i + 3));
    applyStimulus(1, 1, 0, 8'hBB);
    checkOutput("rw_full_cnt", 32'(cnt), 32'd511);
    checkOutput("rw_full_data", 32'(dataOut), 32'h03);
    while (modelQ.size() > 100) applyStimulus(0, 1, 0, 8'h00);

    // Read+write at cnt 100: count stays, order preserved by the model.
    checkOutput("rw100_pre", 32'(cnt), 32'd100);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 8'(8'hC0 + i));
    checkOutput("rw100_cnt", 32'(cnt), 32'd100);
    while (modelQ.size() > 0) applyStimulus(0, 1, 0, 8'h00);
    checkOutput("rw100_last", 32'(dataOut), 32'hC9);

    // Pointer wrap: random traffic bounded to occupancy 200..300.
    while (modelQ.size() < 250) applyStimulus(1, 0, 0, 8'($urandom));
    for (int i = 0; i < 1200; i++) begin
      applyStimulus((modelQ.size() < 300) && ($urandom_range(1, 0) == 1),
                    (modelQ.size() > 200) && ($urandom_range(1, 0) == 1),
                    0, 8'($urandom));
    end
    while (modelQ.size() > 0) applyStimulus(0, 1, 0, 8'h00);

    // Clear with read and write asserted at cnt 37.
    for (int i = 0; i < 37; i++) applyStimulus(1, 0, 0, 8'(8'h40 + i));
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(1, 0, 0, 8'h76);
    checkOutput("clr_pre_cnt", 32'(cnt), 32'd37);
    applyStimulus(1, 1, 1, 8'h99);
    checkOutput("clr_cnt", 32'(cnt), 32'd0);
    checkOutput("clr_empty", 32'(empty), 32'd1);
    checkOutput("clr_hold", 32'(dataOut), 32'h40);
    applyStimulus(1, 0, 0, 8'h5C);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("clr_after_rd", 32'(dataOut), 32'h5C);

    // Asynchronous reset mid-stream after five writes and one read.
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 8'(8'hE0 + i));
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("rst_pre_data", 32'(dataOut), 32'hE0);
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    modelQ.delete();
    expData = 8'h00;
    checkOutput("rst_cnt", 32'(cnt), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_ae", 32'(almostEmpty), 32'd1);
    checkOutput("rst_data", 32'(dataOut), 32'd0);
    compareState();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 8'h12);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("post_rst_rd", 32'(dataOut), 32'h12);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
